// File: rtl/tm1638_pkg.sv
// ============================================================================
// tm1638_pkg
// Shared types and helpers for the TM1638 page scheduler.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package tm1638_pkg;

  typedef logic [1:0] page_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_URGENT = 2'd2
  } state_t;

  localparam int c_NEXT_KEY = 7;

  // Clock cycles per millisecond tick (MS_DIV).
  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Ceiling log2, never below 1 so it is always usable as a width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tm1638_key_debounce.sv
// ============================================================================
// tm1638_key_debounce
// Eight-channel ms-tick debouncer producing one-cycle registered press pulses.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tm1638_key_debounce
  import tm1638_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       i_tick,
  input  logic [7:0] i_keys,
  output logic [7:0] o_press
);

  localparam int              c_CW   = clog2(DEBOUNCE_MS + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_MS - 1);

  logic [7:0]      r_state;
  logic [7:0]      r_press;
  logic [c_CW-1:0] r_cnt [8];

  // Any cycle where the raw key matches the accepted state restarts the count.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_state <= '0;
      r_press <= '0;
      for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
    end else begin
      r_press <= '0;
      for (int k = 0; k < 8; k++) begin
        if (i_keys[k] == r_state[k]) begin
          r_cnt[k] <= '0;
        end else if (i_tick) begin
          if (r_cnt[k] == c_LAST) begin
            r_state[k] <= i_keys[k];
            r_press[k] <= i_keys[k];
            r_cnt[k]   <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/tm1638_page_scheduler.sv
// ============================================================================
// tm1638_page_scheduler
// Time-shares one TM1638 panel between client pages with dwell/NEXT rotation.
// Optional urgent preemption: define TM1638_SCHED_URGENT_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tm1638_page_scheduler
  import tm1638_pkg::*;
#(
  parameter int N_PAGES     = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DWELL_MS    = 2000,
  parameter int DEBOUNCE_MS = 10,
  parameter int URGENT_MS   = 1000
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic [N_PAGES*32-1:0] PAGE_DIGITS_IN,
  input  logic [N_PAGES*8-1:0] PAGE_DOTS_IN,
  input  logic [N_PAGES*8-1:0] PAGE_LEDS_IN,
  input  logic [N_PAGES-1:0]   PAGE_EN_IN,
`ifdef TM1638_SCHED_URGENT_EN
  input  logic [N_PAGES-1:0]   URGENT_IN,
`endif
  input  logic [7:0]           KEYS_IN,
  output logic [31:0]          DISP_DIGITS_OUT,
  output logic [7:0]           DISP_DOTS_OUT,
  output logic [7:0]           DISP_LEDS_OUT,
  output logic [7:0]           KEY_EVT_OUT,
  output logic [1:0]           KEY_EVT_PAGE_OUT,
  output logic [1:0]           CUR_PAGE_OUT,
  output logic                 URGENT_ACT_OUT
);

  localparam int              c_MS_DIV   = ms_div(CLK_HZ);
  localparam int              c_PW       = clog2(c_MS_DIV);
  localparam logic [c_PW-1:0] c_PS_LAST  = c_PW'(c_MS_DIV - 1);
  localparam int              c_DW       = clog2(DWELL_MS + 1);
  localparam logic [c_DW-1:0] c_DW_LAST  = c_DW'(DWELL_MS - 1);
  localparam logic [7:0]      c_FWD_MASK = ~(8'd1 << c_NEXT_KEY);

  // First enabled page at or after start, wrapping; falls back to start.
  function automatic page_t next_en(input logic [N_PAGES-1:0] en, input int start);
    page_t res;
    logic  found;
    int    idx;
    res   = page_t'(start % N_PAGES);
    found = 1'b0;
    for (int i = 0; i < N_PAGES; i++) begin
      idx = (start + i) % N_PAGES;
      for (int p = 0; p < N_PAGES; p++) begin
        if (!found && idx == p && en[p]) begin
          res   = page_t'(p);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  state_t          r_state;
  page_t           r_cur;
  logic [c_PW-1:0] r_ps;
  logic [c_DW-1:0] r_dwell;
  logic [31:0]     r_disp_dig;
  logic [7:0]      r_disp_dots;
  logic [7:0]      r_disp_leds;

  logic            w_tick;
  logic [7:0]      w_press;
  logic            w_next;
  logic            w_any_en;
  logic            w_cur_en;
  logic            w_dwell_exp;
  page_t           w_adv_page;
  page_t           w_idle_page;
  logic [31:0]     w_sel_dig;
  logic [7:0]      w_sel_dots;
  logic [7:0]      w_sel_leds;

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) r_ps <= '0;
    else         r_ps <= w_tick ? '0 : r_ps + 1'b1;
  end

  assign w_tick = (r_ps == c_PS_LAST);

  tm1638_key_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .CLK_IN  (CLK_IN),
    .RST_IN  (RST_IN),
    .i_tick  (w_tick),
    .i_keys  (KEYS_IN),
    .o_press (w_press)
  );

  assign w_next      = w_press[c_NEXT_KEY];
  assign w_any_en    = |PAGE_EN_IN;
  assign w_dwell_exp = w_tick && (r_dwell == c_DW_LAST);
  assign w_adv_page  = next_en(PAGE_EN_IN, int'(r_cur) + 1);
  assign w_idle_page = next_en(PAGE_EN_IN, int'(r_cur));

  always_comb begin
    w_cur_en   = 1'b0;
    w_sel_dig  = '0;
    w_sel_dots = '0;
    w_sel_leds = '0;
    for (int p = 0; p < N_PAGES; p++) begin
      if (r_cur == page_t'(p)) begin
        w_cur_en   = PAGE_EN_IN[p];
        w_sel_dig  = PAGE_DIGITS_IN[p*32 +: 32];
        w_sel_dots = PAGE_DOTS_IN[p*8 +: 8];
        w_sel_leds = PAGE_LEDS_IN[p*8 +: 8];
      end
    end
  end

`ifdef TM1638_SCHED_URGENT_EN
  localparam int              c_UW      = clog2(URGENT_MS + 1);
  localparam logic [c_UW-1:0] c_UR_LAST = c_UW'(URGENT_MS - 1);

  logic [N_PAGES-1:0] r_urg_prev;
  page_t              r_saved;
  logic [c_UW-1:0]    r_urg_cnt;
  logic               r_urg_act;
  logic [N_PAGES-1:0] w_urg_edge;
  page_t              w_urg_page;

  assign w_urg_edge = URGENT_IN & ~r_urg_prev & PAGE_EN_IN;

  always_comb begin
    w_urg_page = '0;
    for (int p = N_PAGES - 1; p >= 0; p--) begin
      if (w_urg_edge[p]) w_urg_page = page_t'(p);
    end
  end

  assign URGENT_ACT_OUT = r_urg_act;
`else
  assign URGENT_ACT_OUT = 1'b0;
`endif

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_dwell     <= '0;
      r_disp_dig  <= '0;
      r_disp_dots <= '0;
      r_disp_leds <= '0;
`ifdef TM1638_SCHED_URGENT_EN
      r_urg_prev  <= '0;
      r_saved     <= '0;
      r_urg_cnt   <= '0;
      r_urg_act   <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE) begin
        r_disp_dig  <= '0;
        r_disp_dots <= '0;
        r_disp_leds <= '0;
      end else begin
        r_disp_dig  <= w_sel_dig;
        r_disp_dots <= w_sel_dots;
        r_disp_leds <= w_sel_leds;
      end
`ifdef TM1638_SCHED_URGENT_EN
      r_urg_prev <= URGENT_IN;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_any_en) begin
            r_cur   <= w_idle_page;
            r_dwell <= '0;
            r_state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
`ifdef TM1638_SCHED_URGENT_EN
          // Preemption discards any advance requested in the same cycle.
          if (|w_urg_edge) begin
            r_saved   <= r_cur;
            r_cur     <= w_urg_page;
            r_urg_cnt <= '0;
            r_urg_act <= 1'b1;
            r_state   <= ST_URGENT;
          end else
`endif
          if (!w_any_en) begin
            r_state <= ST_IDLE;
          end else if (!w_cur_en || w_dwell_exp || w_next) begin
            r_cur   <= w_adv_page;
            r_dwell <= '0;
          end else if (w_tick) begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
`ifdef TM1638_SCHED_URGENT_EN
        ST_URGENT: begin
          // A disabled saved page is handled by the normal SHOW advance.
          if (w_next || (w_tick && r_urg_cnt == c_UR_LAST)) begin
            r_cur     <= r_saved;
            r_dwell   <= '0;
            r_urg_act <= 1'b0;
            r_state   <= ST_SHOW;
          end else if (w_tick) begin
            r_urg_cnt <= r_urg_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DISP_DIGITS_OUT  = r_disp_dig;
  assign DISP_DOTS_OUT    = r_disp_dots;
  assign DISP_LEDS_OUT    = r_disp_leds;
  assign KEY_EVT_OUT      = w_press & c_FWD_MASK;
  assign KEY_EVT_PAGE_OUT = (|KEY_EVT_OUT) ? r_cur : 2'd0;
  assign CUR_PAGE_OUT     = r_cur;

endmodule

`default_nettype wire

// File: tb/tb_tm1638_page_scheduler.sv
// ============================================================================
// tb_tm1638_page_scheduler
// Directed self-checking bench for tm1638_page_scheduler (1 ms = 1000 cycles).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tm1638_page_scheduler;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*32-1:0] digits;
  logic [NP*8-1:0] dots;
  logic [NP*8-1:0] leds;
  logic [NP-1:0]   en;
  logic [NP-1:0]   urg;
  logic [7:0]      keys;
  logic [31:0]     d_dig;
  logic [7:0]      d_dots;
  logic [7:0]      d_leds;
  logic [7:0]      kevt;
  logic [1:0]      kpg;
  logic [1:0]      cur;
  logic            act;

  int errors = 0;
  int checks = 0;
  int cyc;
  int t_base;

  tm1638_page_scheduler #(
    .N_PAGES     (NP),
    .CLK_HZ      (1_000_000),
    .DWELL_MS    (5),
    .DEBOUNCE_MS (3),
    .URGENT_MS   (4)
  ) dut (
    .CLK_IN           (clk),
    .RST_IN           (rst_n),
    .PAGE_DIGITS_IN   (digits),
    .PAGE_DOTS_IN     (dots),
    .PAGE_LEDS_IN     (leds),
    .PAGE_EN_IN       (en),
`ifdef TM1638_SCHED_URGENT_EN
    .URGENT_IN        (urg),
`endif
    .KEYS_IN          (keys),
    .DISP_DIGITS_OUT  (d_dig),
    .DISP_DOTS_OUT    (d_dots),
    .DISP_LEDS_OUT    (d_leds),
    .KEY_EVT_OUT      (kevt),
    .KEY_EVT_PAGE_OUT (kpg),
    .CUR_PAGE_OUT     (cur),
    .URGENT_ACT_OUT   (act)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; ms ticks land on multiples of 1000.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_dig(input int p);
    return 32'h1111_1111 * (p + 1);
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cur !== 2'd0)    begin errors++; $display("FAIL rst_cur: got %0d want 0", cur); end
    checks++; if (d_dig !== 32'd0) begin errors++; $display("FAIL rst_dig: got %h want 0", d_dig); end
    checks++; if (d_dots !== 8'd0 || d_leds !== 8'd0) begin errors++; $display("FAIL rst_dots_leds: got %h/%h want 0/0", d_dots, d_leds); end
    checks++; if (kevt !== 8'd0 || kpg !== 2'd0) begin errors++; $display("FAIL rst_evt: got %h/%0d want 0/0", kevt, kpg); end
    checks++; if (act !== 1'b0)    begin errors++; $display("FAIL rst_act: got %b want 0", act); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (d_dig !== 32'd0 || cur !== 2'd0) begin errors++; $display("FAIL idle_no_en: dig %h cur %0d want 0/0", d_dig, cur); end
  endtask

  task automatic test_rotation();
    logic [1:0] old;
    int t_prev;
    int exp_seq[4] = '{1, 2, 3, 0};
    bit seen;
    en = 4'hF;
    @(negedge clk);
    checks++; if (cur !== 2'd0)    begin errors++; $display("FAIL rot_start_cur: got %0d want 0", cur); end
    checks++; if (d_dig !== 32'd0) begin errors++; $display("FAIL rot_start_lag: got %h want 0", d_dig); end
    @(negedge clk);
    checks++; if (d_dig !== exp_dig(0)) begin errors++; $display("FAIL rot_dig0: got %h want %h", d_dig, exp_dig(0)); end
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      old = cur;
      seen = 1'b0;
      for (int i = 0; i < 6000 && !seen; i++) begin
        @(negedge clk);
        if (cur !== old) seen = 1'b1;
      end
      checks++; if (!seen || cur !== 2'(exp_seq[k])) begin errors++; $display("FAIL rot_page%0d: got %0d want %0d", k, cur, exp_seq[k]); end
      if (k > 0) begin
        checks++; if (cyc - t_prev != 5000) begin errors++; $display("FAIL rot_interval%0d: got %0d want 5000", k, cyc - t_prev); end
      end
      t_prev = cyc;
      checks++; if (d_dig !== exp_dig(int'(old))) begin errors++; $display("FAIL rot_oldlag%0d: got %h want %h", k, d_dig, exp_dig(int'(old))); end
      @(negedge clk);
      checks++; if (d_dig !== exp_dig(exp_seq[k]) || d_dots !== dots[exp_seq[k]*8 +: 8] || d_leds !== leds[exp_seq[k]*8 +: 8]) begin
        errors++; $display("FAIL rot_data%0d: got %h want %h", k, d_dig, exp_dig(exp_seq[k]));
      end
    end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL rot_act: got %b want 0", act); end
  endtask

  task automatic test_disable();
    bit seen;
    en = 4'b0101;
    seen = 1'b0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(negedge clk);
      if (cur === 2'd2) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL dis_reach2: got %0d want 2", cur); end
    en = 4'b0001;
    @(negedge clk);
    checks++; if (cur !== 2'd0) begin errors++; $display("FAIL dis_advance: got %0d want 0", cur); end
    en = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (d_dig !== 32'd0 || d_dots !== 8'd0 || d_leds !== 8'd0) begin errors++; $display("FAIL idle_blank: got %h/%h/%h want 0", d_dig, d_dots, d_leds); end
    en = 4'b0100;
    @(negedge clk);
    checks++; if (cur !== 2'd2) begin errors++; $display("FAIL idle_search: got %0d want 2", cur); end
    en = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (cur !== 2'd2 || d_dig !== 32'd0) begin errors++; $display("FAIL idle_hold: cur %0d dig %h want 2/0", cur, d_dig); end
  endtask

  task automatic test_debounce();
    int n_evt, ev_cyc, m, exp_e;
    logic [7:0] ev_val;
    logic [1:0] ev_pg;
    en = 4'b0010;
    @(negedge clk);
    checks++; if (cur !== 2'd1) begin errors++; $display("FAIL db_select: got %0d want 1", cur); end
    n_evt = 0; ev_cyc = -1; ev_val = '0; ev_pg = '0;
    for (int b = 0; b < 4; b++) begin
      keys[2] = 1'b1;
      repeat (250) begin @(negedge clk); if (kevt !== 8'd0) n_evt++; end
      keys[2] = 1'b0;
      repeat (250) begin @(negedge clk); if (kevt !== 8'd0) n_evt++; end
    end
    keys[2] = 1'b1;
    m = cyc + 1;
    exp_e = ((m + 999) / 1000) * 1000 + 2000;
    while (cyc < exp_e + 5) begin
      @(negedge clk);
      if (kevt !== 8'd0) begin
        n_evt++; ev_cyc = cyc; ev_val = kevt; ev_pg = kpg;
      end
    end
    checks++; if (n_evt != 1)       begin errors++; $display("FAIL db_count: got %0d want 1", n_evt); end
    checks++; if (ev_cyc != exp_e)  begin errors++; $display("FAIL db_latency: got %0d want %0d", ev_cyc, exp_e); end
    checks++; if (ev_val !== 8'h04) begin errors++; $display("FAIL db_value: got %h want 04", ev_val); end
    checks++; if (ev_pg !== 2'd1)   begin errors++; $display("FAIL db_tag: got %0d want 1", ev_pg); end
    keys[2] = 1'b0;
    n_evt = 0;
    repeat (4000) begin @(negedge clk); if (kevt !== 8'd0) n_evt++; end
    checks++; if (n_evt != 0) begin errors++; $display("FAIL db_release: got %0d want 0", n_evt); end
  endtask

  task automatic test_next();
    int a0, a, n_evt, nch;
    int ch_cyc[4];
    logic [1:0] ch_pg[4];
    logic [1:0] old;
    bit seen;
    en = 4'hF;
    old = cur;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (cur !== old) seen = 1'b1;
    end
    a0 = cyc;
    checks++; if (!seen || cur !== 2'd2 || (a0 % 1000) != 0) begin errors++; $display("FAIL nx_pre: cur %0d at %0d want 2 on a tick", cur, a0); end
    a = a0 + 5000;
    wait_cyc(a - 10);
    keys[7] = 1'b1;
    n_evt = 0; nch = 0;
    for (int i = 0; i < 4; i++) begin ch_cyc[i] = -1; ch_pg[i] = '0; end
    while (cyc < a + 7002) begin
      old = cur;
      @(negedge clk);
      if (kevt !== 8'd0) n_evt++;
      if (cur !== old) begin
        if (nch < 4) begin ch_cyc[nch] = cyc; ch_pg[nch] = cur; end
        nch++;
      end
    end
    keys[7] = 1'b0;
    checks++; if (n_evt != 0) begin errors++; $display("FAIL nx_noevt: got %0d want 0", n_evt); end
    checks++; if (nch != 3)   begin errors++; $display("FAIL nx_changes: got %0d want 3", nch); end
    checks++; if (ch_cyc[0] != a || ch_pg[0] !== 2'd3) begin errors++; $display("FAIL nx_dwell: got %0d@%0d want 3@%0d", ch_pg[0], ch_cyc[0], a); end
    checks++; if (ch_cyc[1] != a + 2001 || ch_pg[1] !== 2'd0) begin errors++; $display("FAIL nx_early: got %0d@%0d want 0@%0d", ch_pg[1], ch_cyc[1], a + 2001); end
    checks++; if (ch_cyc[2] != a + 7000 || ch_pg[2] !== 2'd1) begin errors++; $display("FAIL nx_restart: got %0d@%0d want 1@%0d", ch_pg[2], ch_cyc[2], a + 7000); end
    t_base = a + 7000;
  endtask

`ifdef TM1638_SCHED_URGENT_EN
  task automatic test_urgent();
    int b;
    b = t_base;
    wait_cyc(b + 100);
    urg = 4'b1000;
    @(negedge clk);
    checks++; if (cur !== 2'd3 || act !== 1'b1) begin errors++; $display("FAIL urg_enter: cur %0d act %b want 3/1", cur, act); end
    wait_cyc(b + 3999);
    checks++; if (cur !== 2'd3 || act !== 1'b1) begin errors++; $display("FAIL urg_hold: cur %0d act %b want 3/1", cur, act); end
    @(negedge clk);
    checks++; if (cur !== 2'd1 || act !== 1'b0) begin errors++; $display("FAIL urg_exit: cur %0d act %b want 1/0", cur, act); end
    wait_cyc(b + 4100);
    urg = 4'b0000;
    wait_cyc(b + 8999);
    urg = 4'b0001;
    @(negedge clk);
    checks++; if (cur !== 2'd0 || act !== 1'b1) begin errors++; $display("FAIL urg_wins: cur %0d act %b want 0/1", cur, act); end
    wait_cyc(b + 13000);
    checks++; if (cur !== 2'd1 || act !== 1'b0) begin errors++; $display("FAIL urg_restore: cur %0d act %b want 1/0", cur, act); end
    wait_cyc(b + 13050);
    urg = 4'b0000;
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
`ifdef TM1638_SCHED_URGENT_EN
    urg = 4'b0100;
    @(negedge clk);
    checks++; if (cur !== 2'd2 || act !== 1'b1) begin errors++; $display("FAIL ar_pre: cur %0d act %b want 2/1", cur, act); end
`else
    checks++; if (cur !== 2'd1 || act !== 1'b0) begin errors++; $display("FAIL ar_pre: cur %0d act %b want 1/0", cur, act); end
`endif
    #3;
    rst_n = 1'b0;
    urg = 4'b0000;
    #1;
    checks++; if (cur !== 2'd0 || act !== 1'b0 || d_dig !== 32'd0 || d_dots !== 8'd0 || d_leds !== 8'd0) begin
      errors++; $display("FAIL ar_async: cur %0d act %b dig %h dots %h leds %h want all 0", cur, act, d_dig, d_dots, d_leds);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cur !== 2'd0 || d_dig !== 32'd0) begin errors++; $display("FAIL ar_idle: cur %0d dig %h want 0/0", cur, d_dig); end
    @(negedge clk);
    checks++; if (d_dig !== exp_dig(0) || act !== 1'b0) begin errors++; $display("FAIL ar_show: dig %h act %b want %h/0", d_dig, act, exp_dig(0)); end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      digits[p*32 +: 32] = exp_dig(p);
      dots[p*8 +: 8]     = 8'(1 << p);
      leds[p*8 +: 8]     = 8'(8'hA0 | p);
    end
    en   = '0;
    urg  = '0;
    keys = '0;
    t_base = 0;
    test_reset();
    test_rotation();
    test_disable();
    test_debounce();
    test_next();
`ifdef TM1638_SCHED_URGENT_EN
    test_urgent();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tm1638_page_scheduler.md
# tm1638_page_scheduler

Time-shares the single TM1638 display/key panel between up to four client "pages". It sits directly upstream of `tm1638_controller`: it drives that block's digit, dot and LED inputs and consumes its `KEYS` output. Pages rotate on a dwell timer or on a dedicated NEXT key, and any page can preempt the panel through an urgent request. Raw keys are debounced and delivered as one-cycle press events, tagged with the page that owned the panel at the time of the press.

## Interface
Parameters:
- `N_PAGES`, 4: number of client pages, legal range 2..4.
- `CLK_HZ`, 50_000_000: CLK_IN frequency; must be a multiple of 1000.
- `DWELL_MS`, 2000: display time per page in auto-rotation, ≥1.
- `DEBOUNCE_MS`, 10: key stable time before a state change is accepted, ≥1.
- `URGENT_MS`, 1000: hold time of an urgent preemption, ≥1.

Ports:
- `CLK_IN` in 1: clock.
- `RST_IN` in 1: reset, asynchronous, active-low.
- `PAGE_DIGITS_IN` in N_PAGES*32: page p occupies bits [p*32+31:p*32]; digit 0 (leftmost) is the top nibble.
- `PAGE_DOTS_IN` in N_PAGES*8: per-page decimal points.
- `PAGE_LEDS_IN` in N_PAGES*8: per-page LEDs.
- `PAGE_EN_IN` in N_PAGES: page p takes part in rotation.
- `URGENT_IN` in N_PAGES: level request; its rising edge triggers preemption. Present only with the macro.
- `KEYS_IN` in 8: raw keys from `tm1638_controller`.
- `DISP_DIGITS_OUT` out 32: to DIGIT_0..7; DIGIT_0 = [31:28].
- `DISP_DOTS_OUT` out 8, `DISP_LEDS_OUT` out 8: to DOTS/LEDS.
- `KEY_EVT_OUT` out 8: one-cycle press pulses; bit 7 is always 0.
- `KEY_EVT_PAGE_OUT` out 2: owner page of the current `KEY_EVT_OUT` pulse.
- `CUR_PAGE_OUT` out 2: page currently displayed.
- `URGENT_ACT_OUT` out 1: high while in URGENT state.

## Operation
- **ms tick.** A prescaler emits a one-cycle tick every CLK_HZ/1000 cycles. All timers count ticks only.
- **Debounce.** Each key has its own counter. A candidate state differing from the debounced state must stay stable for DEBOUNCE_MS consecutive ticks before it is accepted; any bounce restarts the count.
- **Press events.** A debounced 0→1 transition produces a one-cycle `KEY_EVT_OUT` pulse. Releases produce no event.
- **NEXT key.** Key 7 is reserved as NEXT and is never forwarded.
- **FSM states.** IDLE, SHOW, URGENT.
- **IDLE.** Entered when no page is enabled. Display outputs are 0 and `CUR_PAGE_OUT` holds its last value. When any page becomes enabled, the FSM goes to SHOW on the first enabled page, searching circularly from `CUR_PAGE_OUT`.
- **SHOW.** The dwell counter increments per tick. On the DWELL_MS-th tick, or on a NEXT press, the FSM advances to the next enabled page by circular search from cur+1 and clears the dwell counter.
  - If cur is the only enabled page, it stays selected and only the counter clears.
  - If the current page becomes disabled, the FSM advances on the next cycle.
  - Dwell expiry and NEXT in the same cycle cause exactly one advance.
- **URGENT** (macro only). A rising edge of `URGENT_IN[i]` on an enabled page saves cur and selects the lowest-index page with an edge.
  - The urgent page is held for URGENT_MS ticks or until a NEXT press, then SHOW resumes on the saved page with a cleared dwell counter. If the saved page is now disabled, normal advance applies.
  - Further urgent edges while in URGENT are ignored.
  - An urgent edge in the same cycle as NEXT or dwell expiry: urgent wins and the advance is discarded.
- **Event tagging.** `KEY_EVT_PAGE_OUT` is the page displayed in the cycle the event is emitted, including during URGENT.
- **Reset values.** All outputs are 0, the state is IDLE, and all counters and debounced keys are 0. An asynchronous reset mid-dwell or mid-urgent abandons the state immediately.

## Timing
- Display outputs are registered. Selected page data appears 1 cycle after `CUR_PAGE_OUT` changes, and page-data changes propagate in 1 cycle.
- Debounce latency: a clean edge on `KEYS_IN` yields its event DEBOUNCE_MS ticks later, aligned to a tick, plus 1 cycle.
- A NEXT press advances `CUR_PAGE_OUT` in the cycle after the internal NEXT event.
- The dwell counter and prescaler are free-running from state entry, so a page shows for between DWELL_MS−1 and DWELL_MS ms.

## Configuration
- **`TM1638_SCHED_URGENT_EN` defined:** the `URGENT_IN` port, the URGENT state, the saved-page register and the urgent timer are compiled in.
- **Not defined:** `URGENT_IN` is absent and `URGENT_ACT_OUT` is tied to 0. Only IDLE and SHOW exist.

## Structure
- Shared package `tm1638_pkg` holds:
  - the page index type (2 bits);
  - the FSM state enum;
  - `MS_DIV = CLK_HZ/1000`;
  - a `clog2` helper for counter widths;
  - the NEXT key index constant 7.
- Sub-module `tm1638_key_debounce` holds the 8-channel debounce and press-edge logic, driven by the ms tick. It is instantiated once.

## Test plan
Bench parameters: CLK_HZ=1_000_000, DWELL_MS=5, DEBOUNCE_MS=3, URGENT_MS=4.
- Enable pages 0..3 with distinct digits → CUR_PAGE sequence 0,1,2,3,0 with ~5000 cycles per page; each digit change appears 1 cycle after the CUR_PAGE change.
- `PAGE_EN=4'b0101`, then disable page 2 while it is shown → next cycle advances to 0. Then `PAGE_EN=0` → IDLE, digits/dots/LEDs = 0.
- `KEYS_IN[2]` bounces for 2 ms, then is held high → exactly one `KEY_EVT_OUT=8'h04` pulse, about 3 ms after the last bounce, with `KEY_EVT_PAGE_OUT` equal to the current page.
- Press key 7 at dwell 2 ms → page advances early, no key event emitted, dwell restarts at 0.
- Macro on, showing page 1: raise `URGENT_IN=4'b1000` → page 3 with `URGENT_ACT=1` for 4 ms, then page 1 again. Raise `URGENT_IN[0]` in the same cycle as dwell expiry → urgent wins.
- Assert RST_IN low mid-URGENT → all outputs 0 asynchronously; after release, FSM restarts from IDLE.
